// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundles the two fetch ports and the shared RAM port.
// The arbiter connects through the slave modport; the cores plus the RAM
// (or a bench standing in for them) connect through the master modport.
interface imem_arbiter_if;
  logic        iREN0;
  logic        iREN1;
  logic [31:0] iaddr0;
  logic [31:0] iaddr1;
  logic        ihit0;
  logic        ihit1;
  logic [31:0] iload0;
  logic [31:0] iload1;
  logic        ramREN;
  logic [31:0] ramaddr;
  logic [31:0] ramload;
  logic        ramready;
  logic        arb_err;

  modport slave (
    input  iREN0, iREN1, iaddr0, iaddr1, ramload, ramready,
    output ihit0, ihit1, iload0, iload1, ramREN, ramaddr, arb_err
  );

  modport master (
    output iREN0, iREN1, iaddr0, iaddr1, ramload, ramready,
    input  ihit0, ihit1, iload0, iload1, ramREN, ramaddr, arb_err
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin arbiter sharing one single-ported instruction
// RAM between the fetch stages of two cores. One access is in flight at a
// time (IDLE -> BUSYn -> RESPn) and every result comes back as a registered
// one-cycle hit pulse to the core that was granted.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES cycles without ramready, returning 32'hFFFFFFFF and setting
// the sticky arb_err flag. Without the macro BUSY waits forever and arb_err
// is tied low.
module imem_arbiter
`ifdef ARB_TIMEOUT_EN
  #(parameter logic [7:0] TIMEOUT_CYCLES = 8'd16)
`endif
  (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY0,
    BUSY1,
    RESP0,
    RESP1
  } state_t;

  state_t      state_q;
  logic        last_q;
  logic        ramREN_q;
  logic [31:0] ramaddr_q;
  logic        ihit0_q;
  logic        ihit1_q;
  logic [31:0] iload0_q;
  logic [31:0] iload1_q;

  logic        reqValid_d;
  logic        grant1_d;
  logic [31:0] grantAddr_d;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]  cnt_q;
  logic        arbErr_q;
`endif

  // Grant decision: a lone request wins outright; on a tie the core that was not served last wins.
  always_comb begin
    reqValid_d  = bus.iREN0 | bus.iREN1;
    grant1_d    = bus.iREN1 & (~bus.iREN0 | ~last_q);
    grantAddr_d = grant1_d ? bus.iaddr1 : bus.iaddr0;
  end

  // Main FSM: sequences one RAM access at a time and registers every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      ramREN_q  <= 1'b0;
      ramaddr_q <= 32'd0;
      ihit0_q   <= 1'b0;
      ihit1_q   <= 1'b0;
      iload0_q  <= 32'd0;
      iload1_q  <= 32'd0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      arbErr_q  <= 1'b0;
`endif
    end else begin
      ihit0_q <= 1'b0;
      ihit1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (reqValid_d) begin
            state_q   <= grant1_d ? BUSY1 : BUSY0;
            last_q    <= grant1_d;
            ramaddr_q <= grantAddr_d;
            ramREN_q  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
          end
        end
        BUSY0, BUSY1: begin
          if (bus.ramready) begin
            ramREN_q <= 1'b0;
            if (state_q == BUSY1) begin
              iload1_q <= bus.ramload;
              ihit1_q  <= 1'b1;
              state_q  <= RESP1;
            end else begin
              iload0_q <= bus.ramload;
              ihit0_q  <= 1'b1;
              state_q  <= RESP0;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt_q == TIMEOUT_CYCLES - 8'd1) begin
            ramREN_q <= 1'b0;
            arbErr_q <= 1'b1;
            if (state_q == BUSY1) begin
              iload1_q <= 32'hFFFF_FFFF;
              ihit1_q  <= 1'b1;
              state_q  <= RESP1;
            end else begin
              iload0_q <= 32'hFFFF_FFFF;
              ihit0_q  <= 1'b1;
              state_q  <= RESP0;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        RESP0, RESP1: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ramREN  = ramREN_q;
  assign bus.ramaddr = ramaddr_q;
  assign bus.ihit0   = ihit0_q;
  assign bus.ihit1   = ihit1_q;
  assign bus.iload0  = iload0_q;
  assign bus.iload1  = iload1_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.arb_err = arbErr_q;
`else
  assign bus.arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter. A combined core/RAM
// agent drives requests and RAM responses on the falling edge and compares
// every hit against an expected-result queue filled when requests are
// issued. The timeout scenario follows ARB_TIMEOUT_EN.
module tb_imem_arbiter;

  logic clk;
  logic rst;

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        core;
    logic [31:0] addr;
    logic [31:0] data;
  } expEntry_t;

  expEntry_t   expQ[$];
  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cyc         = 0;
  int          reqLeft[2];
  logic [31:0] nextAddr[2];
  logic [31:0] lastLoad[2];
  int          hitsSeen[2];
  int          lastHitCyc[2];
  int          ramLat      = 1;
  bit          ramNever    = 1'b0;
  bit          scramble    = 1'b0;
  logic        lastModel   = 1'b1;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, advanced at the start of each cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Contents of the fake instruction memory.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    case (a)
      32'h0000_0000: memFn = 32'h3401_D269;
      32'h0000_0004: memFn = 32'h3402_37F1;
      32'h0000_0010: memFn = 32'h0022_1825;
      default:       memFn = {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Loads request plans for both cores and pushes the expected hit sequence.
  // mode 0: normal data, mode 1: halt word, mode 2: no response expected.
  task automatic applyStimulus(input int n0, input logic [31:0] b0, input int n1,
                               input logic [31:0] b1, input int mode, output int startCyc);
    int          r0;
    int          r1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        c;
    expEntry_t   e;
    r0 = n0; r1 = n1; a0 = b0; a1 = b1;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) c = ~lastModel;
      else                  c = (r1 > 0);
      lastModel = c;
      e.core = c;
      e.addr = c ? a1 : a0;
      e.data = (mode == 1) ? 32'hFFFF_FFFF : memFn(e.addr);
      if (mode != 2) expQ.push_back(e);
      if (c) begin r1--; a1 += 4; end
      else   begin r0--; a0 += 4; end
    end
    reqLeft[0]  = n0;
    reqLeft[1]  = n1;
    nextAddr[0] = b0;
    nextAddr[1] = b1;
    startCyc    = cyc;
  endtask

  // Waits, with a cycle budget, until both cores have consumed their plans.
  task automatic waitDone(input int budget);
    int i;
    i = 0;
    while ((reqLeft[0] > 0 || reqLeft[1] > 0) && i < budget) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (reqLeft[0] > 0 || reqLeft[1] > 0)
      checkOutput("waitBudget", 32'(reqLeft[0] + reqLeft[1]), 32'd0);
  endtask

  // Core and RAM agent: checks outputs, then drives inputs, on the falling edge.
  initial begin : agent
    int        busyCnt;
    int        c;
    expEntry_t e;
    busyCnt      = 0;
    reqLeft[0]   = 0;
    reqLeft[1]   = 0;
    nextAddr[0]  = 32'd0;
    nextAddr[1]  = 32'd0;
    lastLoad[0]  = 32'd0;
    lastLoad[1]  = 32'd0;
    hitsSeen[0]  = 0;
    hitsSeen[1]  = 0;
    lastHitCyc[0] = 0;
    lastHitCyc[1] = 0;
    bus.iREN0    = 1'b0;
    bus.iREN1    = 1'b0;
    bus.iaddr0   = 32'd0;
    bus.iaddr1   = 32'd0;
    bus.ramload  = 32'd0;
    bus.ramready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ihit0 || bus.ihit1) begin
        checkOutput("hitExclusive", 32'(bus.ihit0 & bus.ihit1), 32'd0);
        c = bus.ihit1 ? 1 : 0;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedHit", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("hitCore", 32'(c), 32'(e.core));
          checkOutput("hitData", (c == 1) ? bus.iload1 : bus.iload0, e.data);
          checkOutput("loadHold", (c == 1) ? bus.iload0 : bus.iload1, lastLoad[1 - c]);
          lastLoad[c] = e.data;
        end
        hitsSeen[c]++;
        lastHitCyc[c] = cyc;
        if (reqLeft[c] > 0) begin
          reqLeft[c]--;
          nextAddr[c] += 32'd4;
        end
      end else if (bus.ramREN && expQ.size() > 0) begin
        checkOutput("ramaddr", bus.ramaddr, expQ[0].addr);
      end

      bus.iREN0  = (reqLeft[0] > 0);
      bus.iREN1  = (reqLeft[1] > 0);
      bus.iaddr0 = (scramble && bus.ramREN) ? $urandom : nextAddr[0];
      bus.iaddr1 = nextAddr[1];

      if (bus.ramREN) begin
        busyCnt++;
        if (!ramNever && busyCnt == ramLat) begin
          bus.ramready = 1'b1;
          bus.ramload  = memFn(bus.ramaddr);
        end else begin
          bus.ramready = 1'b0;
          bus.ramload  = $urandom;
        end
      end else begin
        busyCnt      = 0;
        bus.ramready = 1'($urandom_range(0, 1));
        bus.ramload  = $urandom;
      end
    end
  end

  // Test sequence.
  initial begin : main
    int s;
    int h0;
    int h1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstIhit0",   32'(bus.ihit0),   32'd0);
    checkOutput("rstIhit1",   32'(bus.ihit1),   32'd0);
    checkOutput("rstIload0",  bus.iload0,       32'd0);
    checkOutput("rstIload1",  bus.iload1,       32'd0);
    checkOutput("rstRamREN",  32'(bus.ramREN),  32'd0);
    checkOutput("rstRamaddr", bus.ramaddr,      32'd0);
    checkOutput("rstArbErr",  32'(bus.arb_err), 32'd0);
    rst = 1'b0;

    $display("[TB] tie after reset");
    @(posedge clk); #1;
    applyStimulus(1, 32'h00, 1, 32'h10, 0, s);
    waitDone(30);
    checkOutput("tieLat0", 32'(lastHitCyc[0] - s), 32'd2);
    checkOutput("tieLat1", 32'(lastHitCyc[1] - s), 32'd5);

    $display("[TB] single request");
    h1 = hitsSeen[1];
    applyStimulus(1, 32'h04, 0, 32'h00, 0, s);
    waitDone(30);
    checkOutput("singleLat", 32'(lastHitCyc[0] - s), 32'd2);
    checkOutput("singleNoHit1", 32'(hitsSeen[1] - h1), 32'd0);

    $display("[TB] sustained contention");
    h0 = hitsSeen[0];
    h1 = hitsSeen[1];
    applyStimulus(6, 32'h100, 6, 32'h200, 0, s);
    waitDone(200);
    checkOutput("contHits0", 32'(hitsSeen[0] - h0), 32'd6);
    checkOutput("contHits1", 32'(hitsSeen[1] - h1), 32'd6);
    checkOutput("contLastHit", 32'((lastHitCyc[0] > lastHitCyc[1] ? lastHitCyc[0] : lastHitCyc[1]) - s), 32'd35);

    $display("[TB] wait states");
    ramLat   = 4;
    scramble = 1'b1;
    applyStimulus(1, 32'h20, 0, 32'h00, 0, s);
    waitDone(40);
    checkOutput("waitLat", 32'(lastHitCyc[0] - s), 32'd5);
    scramble = 1'b0;
    ramLat   = 1;

    $display("[TB] timeout");
    ramNever = 1'b1;
`ifdef ARB_TIMEOUT_EN
    applyStimulus(0, 32'h00, 1, 32'h40, 1, s);
    waitDone(60);
    checkOutput("toLat", 32'(lastHitCyc[1] - s), 32'd17);
    checkOutput("toArbErr", 32'(bus.arb_err), 32'd1);
    ramNever = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("toArbErrSticky", 32'(bus.arb_err), 32'd1);
    applyStimulus(0, 32'h00, 1, 32'h44, 0, s);
    waitDone(30);
    checkOutput("toRecoverLat", 32'(lastHitCyc[1] - s), 32'd2);
    checkOutput("toArbErrKept", 32'(bus.arb_err), 32'd1);
`else
    h1 = hitsSeen[1];
    applyStimulus(0, 32'h00, 1, 32'h40, 2, s);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("noToBusy", 32'(bus.ramREN), 32'd1);
    checkOutput("noToHit", 32'(hitsSeen[1] - h1), 32'd0);
    checkOutput("noToArbErr", 32'(bus.arb_err), 32'd0);
`endif

    $display("[TB] reset mid-access");
    ramNever = 1'b1;
    if (reqLeft[1] == 0) begin
      applyStimulus(0, 32'h00, 1, 32'h80, 2, s);
      repeat (3) @(posedge clk);
      #1;
    end
    checkOutput("midBusy", 32'(bus.ramREN), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    reqLeft[0]  = 0;
    reqLeft[1]  = 0;
    expQ.delete();
    lastLoad[0] = 32'd0;
    lastLoad[1] = 32'd0;
    lastModel   = 1'b1;
    ramNever    = 1'b0;
    h0 = hitsSeen[0];
    h1 = hitsSeen[1];
    checkOutput("midIhit1",   32'(bus.ihit1),   32'd0);
    checkOutput("midIload0",  bus.iload0,       32'd0);
    checkOutput("midIload1",  bus.iload1,       32'd0);
    checkOutput("midRamREN",  32'(bus.ramREN),  32'd0);
    checkOutput("midRamaddr", bus.ramaddr,      32'd0);
    checkOutput("midArbErr",  32'(bus.arb_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midNoHit", 32'(hitsSeen[0] + hitsSeen[1] - h0 - h1), 32'd0);

    $display("[TB] tie after mid-access reset");
    @(posedge clk); #1;
    applyStimulus(1, 32'h00, 1, 32'h10, 0, s);
    waitDone(30);
    checkOutput("tie2Lat0", 32'(lastHitCyc[0] - s), 32'd2);
    checkOutput("tie2Lat1", 32'(lastHitCyc[1] - s), 32'd5);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
